// File: rtl/alu_muldiv_if.sv
// rtl/alu_muldiv_if.sv - operand, control and result bundle between execute stage and alu_muldiv
interface alu_muldiv_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic [3:0]       ALUControl;
   logic             start;
   logic [WIDTH-1:0] ALUResult;
   logic             zero;
   logic             overflow;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   modport master (
      output SrcA, SrcB, ALUControl, start,
      input  ALUResult, zero, overflow, busy, done, HI, LO
   );

   modport slave (
      input  SrcA, SrcB, ALUControl, start,
      output ALUResult, zero, overflow, busy, done, HI, LO
   );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - combinational ALU plus iterative shift-add multiply / restoring divide with HI/LO
module alu_muldiv #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_muldiv_if.slave bus
);
   localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010, OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLTU = 4'b0100, OP_SLL  = 4'b0101, OP_SUB  = 4'b0110, OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000, OP_SRA  = 4'b1001, OP_MFHI = 4'b1010, OP_MFLO = 4'b1011;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state, w_next;
   logic [SHW-1:0]     r_cnt;
   logic [2*WIDTH-1:0] r_p;
   logic [WIDTH-1:0]   r_mc;
   logic               r_div, r_neg_p, r_neg_r, r_bzero;
   logic [WIDTH-1:0]   r_hi, r_lo;

   logic [WIDTH-1:0]   w_a, w_b, w_sum, w_diff, w_result;
   logic [SHW-1:0]     w_shamt;
   logic               w_ovf;
   logic               w_start_md, w_last, w_busy, w_done;
   logic               w_sgn_op, w_a_neg, w_b_neg;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag;
   logic [WIDTH:0]     w_madd, w_rsh, w_rsub;
   logic [2*WIDTH-1:0] w_p_step, w_prod;
   logic [WIDTH-1:0]   w_quo, w_rem, w_hi_fin, w_lo_fin;

   assign w_a     = bus.SrcA;
   assign w_b     = bus.SrcB;
   assign w_shamt = bus.SrcB[SHW-1:0];
   assign w_sum   = w_a + w_b;
   assign w_diff  = w_a - w_b;

   always_comb begin
      w_result = '0;
      w_ovf    = 1'b0;
      case (bus.ALUControl)
         OP_AND:  w_result = w_a & w_b;
         OP_OR:   w_result = w_a | w_b;
         OP_ADD: begin
            w_result = w_sum;
            w_ovf    = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
         end
         OP_XOR:  w_result = w_a ^ w_b;
         OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
         OP_SLL:  w_result = w_a << w_shamt;
         OP_SUB: begin
            w_result = w_diff;
            w_ovf    = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
         end
         OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
         OP_SRL:  w_result = w_a >> w_shamt;
         OP_SRA:  w_result = $signed(w_a) >>> w_shamt;
         OP_MFHI: w_result = r_hi;
         OP_MFLO: w_result = r_lo;
         default: w_result = '0;
      endcase
   end

   assign bus.ALUResult = w_result;
   assign bus.zero      = (w_result == '0);
   assign bus.overflow  = w_ovf;

   // Signed ops iterate on magnitudes; the sign is reapplied at the final write
   assign w_start_md = bus.start && (bus.ALUControl[3:2] == 2'b11);
   assign w_sgn_op   = ~bus.ALUControl[0];
   assign w_a_neg    = w_sgn_op & bus.SrcA[WIDTH-1];
   assign w_b_neg    = w_sgn_op & bus.SrcB[WIDTH-1];
   assign w_a_mag    = w_a_neg ? (~bus.SrcA + 1'b1) : bus.SrcA;
   assign w_b_mag    = w_b_neg ? (~bus.SrcB + 1'b1) : bus.SrcB;
   assign w_last     = (r_cnt == SHW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start_md) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy = (r_state == S_RUN);
      w_done = (r_state == S_DONE);
   end

   assign bus.busy = w_busy;
   assign bus.done = w_done;

   // r_p is {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
   always_comb begin
      w_madd = {1'b0, r_p[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){r_p[0]}} & {1'b0, r_mc});
      w_rsh  = r_p[2*WIDTH-1:WIDTH-1];
      w_rsub = w_rsh - {1'b0, r_mc};
      if (r_div)
         w_p_step = w_rsub[WIDTH] ? {r_p[2*WIDTH-2:0], 1'b0}
                                  : {w_rsub[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
      else
         w_p_step = {w_madd, r_p[WIDTH-1:1]};
   end

   always_comb begin
      w_prod = r_neg_p ? -w_p_step : w_p_step;
      w_quo  = w_p_step[WIDTH-1:0];
      w_rem  = w_p_step[2*WIDTH-1:WIDTH];
      if (r_div) begin
         w_lo_fin = r_bzero ? '1 : (r_neg_p ? -w_quo : w_quo);
         w_hi_fin = r_neg_r ? -w_rem : w_rem;
      end else begin
         w_hi_fin = w_prod[2*WIDTH-1:WIDTH];
         w_lo_fin = w_prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_p     <= '0;
         r_mc    <= '0;
         r_div   <= 1'b0;
         r_neg_p <= 1'b0;
         r_neg_r <= 1'b0;
         r_bzero <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_start_md) begin
            r_cnt   <= '0;
            r_p     <= {{WIDTH{1'b0}}, w_a_mag};
            r_mc    <= w_b_mag;
            r_div   <= bus.ALUControl[1];
            r_neg_p <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_bzero <= (bus.SrcB == '0);
         end
      end else if (r_state == S_RUN) begin
         r_p   <= w_p_step;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_hi <= w_hi_fin;
            r_lo <= w_lo_fin;
         end
      end
   end

   assign bus.HI = r_hi;
   assign bus.LO = r_lo;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv against an arithmetic reference model
module tb_alu_muldiv;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_muldiv_if #(.WIDTH(W)) bus();
   alu_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_errors = 0;
   logic [2*W-1:0] sb_q[$];
   logic [W-1:0]   m_hi = '0;
   logic [W-1:0]   m_lo = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, b, hi, lo,
                                   output logic [W-1:0] r, output logic ov);
      longint sa, sb, s, lim_hi, lim_lo;
      int sh;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % W);
      lim_hi = (longint'(1) << (W - 1)) - 1;
      lim_lo = -(longint'(1) << (W - 1));
      r = '0;
      ov = 1'b0;
      case (op)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd2: begin s = sa + sb; r = W'(s); ov = (s > lim_hi) || (s < lim_lo); end
         4'd3: r = a ^ b;
         4'd4: r = (a < b) ? 1 : 0;
         4'd5: r = a << sh;
         4'd6: begin s = sa - sb; r = W'(s); ov = (s > lim_hi) || (s < lim_lo); end
         4'd7: r = (sa < sb) ? 1 : 0;
         4'd8: r = a >> sh;
         4'd9: r = W'(sa >>> sh);
         4'd10: r = hi;
         4'd11: r = lo;
         default: r = '0;
      endcase
   endfunction

   function automatic logic [2*W-1:0] ref_md(input logic [1:0] op, input logic [W-1:0] a, b);
      longint sa, sb, q, rm;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: return 64'(sa * sb);
         2'b01: begin up = {32'b0, a} * {32'b0, b}; return up; end
         2'b10: begin
            if (b == 0) return {a, {W{1'b1}}};
            q = sa / sb;
            rm = sa % sb;
            return {W'(rm), W'(q)};
         end
         default: begin
            if (b == 0) return {a, {W{1'b1}}};
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic check_comb(input string nm);
      logic [W-1:0] r;
      logic ov;
      ref_alu(bus.ALUControl, bus.SrcA, bus.SrcB, m_hi, m_lo, r, ov);
      chk({nm, "_res"}, bus.ALUResult, r);
      chk({nm, "_ovf"}, bus.overflow, ov);
      chk({nm, "_zero"}, bus.zero, (r == 0));
   endtask

   task automatic comb_dir(input string nm, input logic [3:0] op, input logic [W-1:0] a, b,
                           input logic [W-1:0] er, input logic eo, input logic ez);
      @(negedge clk);
      bus.SrcA = a; bus.SrcB = b; bus.ALUControl = op; bus.start = 1'b0;
      #1;
      chk({nm, "_res"}, bus.ALUResult, er);
      chk({nm, "_ovf"}, bus.overflow, eo);
      chk({nm, "_zero"}, bus.zero, ez);
      check_comb({nm, "_model"});
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom % 8)
         0: return '0;
         1: return {1'b1, {(W-1){1'b0}}};
         2: return '1;
         3: return 1;
         default: return W'($urandom);
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   logic [2*W-1:0] m_exp;
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done actual=1 expected=0");
         end else begin
            m_exp = sb_q.pop_front();
            chk("md_HI", bus.HI, m_exp[2*W-1:W]);
            chk("md_LO", bus.LO, m_exp[W-1:0]);
            m_hi = m_exp[2*W-1:W];
            m_lo = m_exp[W-1:0];
         end
      end
   end

   task automatic do_md(input logic [1:0] op, input logic [W-1:0] a, b,
                        input bit use_lit, input logic [2*W-1:0] lit, input bit noisy);
      int lat;
      bit busy_ok;
      @(negedge clk);
      bus.SrcA = a; bus.SrcB = b; bus.ALUControl = {2'b11, op}; bus.start = 1'b1;
      sb_q.push_back(use_lit ? lit : ref_md(op, a, b));
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_launch", bus.busy, 1);
      busy_ok = 1'b1;
      lat = 0;
      for (int j = 2; j <= 40; j++) begin
         if (noisy) begin
            bus.SrcA = pick(); bus.SrcB = pick();
            bus.ALUControl = 4'($urandom); bus.start = 1'($urandom);
            #1;
            check_comb("run_comb");
         end
         @(negedge clk);
         if (bus.done) begin lat = j; break; end
         if (!bus.busy) busy_ok = 1'b0;
      end
      chk("busy_held", busy_ok, 1);
      chk("done_latency", lat, W + 1);
      chk("busy_in_done", bus.busy, 0);
      bus.ALUControl = {2'b11, 2'($urandom)};
      bus.start = noisy;
      @(negedge clk);
      bus.start = 1'b0;
      chk("done_one_cycle", bus.done, 0);
   endtask

   initial begin
      logic [1:0] op;
      logic [W-1:0] a, b;
      rst_n = 1'b0;
      bus.SrcA = '0; bus.SrcB = '0; bus.ALUControl = '0; bus.start = 1'b0;
      #2;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_HI", bus.HI, 0);
      chk("rst_LO", bus.LO, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      comb_dir("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 1'b0);
      comb_dir("sub_zero", 4'b0110, 32'd5, 32'd5, 32'h0, 1'b0, 1'b1);
      comb_dir("slt", 4'b0111, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0);
      comb_dir("sltu", 4'b0100, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1);
      comb_dir("sra", 4'b1001, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0);
      comb_dir("mfhi_rst", 4'b1010, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b1);

      do_md(2'b00, 32'hFFFFFFFE, 32'd3, 1, {32'hFFFFFFFF, 32'hFFFFFFFA}, 0);
      do_md(2'b01, 32'hFFFFFFFE, 32'd3, 1, {32'h00000002, 32'hFFFFFFFA}, 1);
      do_md(2'b10, 32'hFFFFFFF9, 32'd2, 1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
      do_md(2'b11, 32'hFFFFFFF9, 32'd2, 1, {32'h00000001, 32'h7FFFFFFC}, 1);
      do_md(2'b11, 32'd7, 32'd0, 1, {32'h00000007, 32'hFFFFFFFF}, 0);
      do_md(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, {32'h00000000, 32'h80000000}, 1);

      for (int i = 0; i < 12; i++) begin
         op = 2'($urandom);
         a = pick();
         b = pick();
         do_md(op, a, b, 0, '0, 1);
      end

      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         bus.SrcA = pick(); bus.SrcB = pick(); bus.ALUControl = 4'($urandom % 12); bus.start = 1'b0;
         #1;
         check_comb("idle_comb");
      end

      @(negedge clk);
      bus.SrcA = 32'hFFFFFFFE; bus.SrcB = 32'd3; bus.ALUControl = 4'b1100; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      bus.SrcA = 32'd20; bus.SrcB = 32'd22; bus.ALUControl = 4'b0010;
      #1;
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_HI", bus.HI, 0);
      chk("midrst_LO", bus.LO, 0);
      chk("midrst_add", bus.ALUResult, 32'd42);
      m_hi = '0;
      m_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      do_md(2'b11, 32'd100, 32'd7, 1, {32'd2, 32'd14}, 0);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
